noc_flit_serializer: RTL and testbench

- Transmit-side counterpart of the router's receive path: accepts one full-width packet per valid/ready handshake and emits it as a sequence of narrower flits on a valid/ready link.
- Each flit carries head and tail markers.
- Sits between the router output port and the physical link, downstream of the output buffering.
- The peer flit deserializer reassembles packets from this flit stream.

---
 rtl/noc_ser_pkg.sv | 9 +
 rtl/flit_shift_reg.sv | 33 +++
 rtl/noc_flit_serializer.sv | 124 ++++++++++++
 tb/tb_noc_flit_serializer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_ser_pkg.sv
// Shared types and default widths for the NoC flit serializer.
package noc_ser_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} ser_state_t;

  localparam int PKT_WIDTH_DEF  = 512;
  localparam int FLIT_WIDTH_DEF = 128;

endpackage

// File: rtl/flit_shift_reg.sv
// Parallel-load, shift-right-by-one-flit register; the low flit is the one on the link.
module flit_shift_reg
  import noc_ser_pkg::*;
#(
  parameter int BIT_WIDTH  = PKT_WIDTH_DEF,
  parameter int FLIT_WIDTH = FLIT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  load,
  input  logic                  shift,
  input  logic [BIT_WIDTH-1:0]  d,
  output logic [FLIT_WIDTH-1:0] q_low
);

  logic [BIT_WIDTH-1:0] q_r;

  // load wins over shift so a back-to-back reload replaces the drained tail
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= d;
    end else if (shift) begin
      q_r <= q_r >> FLIT_WIDTH;
    end else begin
      q_r <= q_r;
    end
  end

  assign q_low = q_r[FLIT_WIDTH-1:0];

endmodule

// File: rtl/noc_flit_serializer.sv
// Packet-to-flit serializer with head/tail markers on a valid/ready link.
// Optional flit_parity output enabled by defining NOC_FLIT_PARITY_EN.
module noc_flit_serializer
  import noc_ser_pkg::*;
#(
  parameter int BIT_WIDTH  = PKT_WIDTH_DEF,
  parameter int FLIT_WIDTH = FLIT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic [BIT_WIDTH-1:0]  pkt_in,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  output logic [FLIT_WIDTH-1:0] flit_out,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic                  flit_head,
  output logic                  flit_tail,
  output logic                  busy
`ifdef NOC_FLIT_PARITY_EN
  ,
  output logic                  flit_parity
`endif
);

  localparam int NUM_FLITS = BIT_WIDTH / FLIT_WIDTH;
  localparam int CNT_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_FLITS - 1);

  if (NUM_FLITS < 2) begin : g_bad_num_flits
    $error("noc_flit_serializer: NUM_FLITS must be >= 2");
  end
  if ((BIT_WIDTH % FLIT_WIDTH) != 0) begin : g_bad_ratio
    $error("noc_flit_serializer: BIT_WIDTH must be a multiple of FLIT_WIDTH");
  end

  ser_state_t       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             load_s, shift_s, pkt_ready_s;

  // State and flit counter registers
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state, counter and shift-register control
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    load_s      = 1'b0;
    shift_s     = 1'b0;
    pkt_ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        pkt_ready_s = 1'b1;
        if (pkt_valid) begin
          load_s      = 1'b1;
          cnt_nxt_s   = '0;
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (flit_ready) begin
          if (cnt_r == LAST) begin
            // tail leaves this cycle: accept the next packet with no bubble
            pkt_ready_s = 1'b1;
            if (pkt_valid) begin
              load_s    = 1'b1;
              cnt_nxt_s = '0;
            end else begin
              shift_s     = 1'b1;
              state_nxt_s = IDLE;
            end
          end else begin
            shift_s   = 1'b1;
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  flit_shift_reg #(
    .BIT_WIDTH  (BIT_WIDTH),
    .FLIT_WIDTH (FLIT_WIDTH)
  ) u_shift (
    .clk   (clk),
    .rst_l (rst_l),
    .load  (load_s),
    .shift (shift_s),
    .d     (pkt_in),
    .q_low (flit_out)
  );

  assign pkt_ready  = pkt_ready_s & rst_l;
  assign flit_valid = (state_r == SEND);
  assign busy       = (state_r == SEND);
  assign flit_head  = (state_r == SEND) && (cnt_r == '0);
  assign flit_tail  = (state_r == SEND) && (cnt_r == LAST);

`ifdef NOC_FLIT_PARITY_EN
  function automatic logic even_parity(input logic [FLIT_WIDTH-1:0] v);
    return ^v;
  endfunction

  // derived only from the flit register, so it holds and resets with flit_out
  assign flit_parity = even_parity(flit_out);
`endif

endmodule

// File: tb/tb_noc_flit_serializer.sv
// Scoreboard bench for noc_flit_serializer: directed scenarios plus randomized traffic.
module tb_noc_flit_serializer;
  import noc_ser_pkg::*;

  localparam int BW = 512;
  localparam int FW = 128;
  localparam int NF = BW / FW;

  logic          clk = 1'b0;
  logic          rst_l;
  logic [BW-1:0] pkt_in;
  logic          pkt_valid;
  logic          pkt_ready;
  logic [FW-1:0] flit_out;
  logic          flit_valid;
  logic          flit_ready;
  logic          flit_head;
  logic          flit_tail;
  logic          busy;
`ifdef NOC_FLIT_PARITY_EN
  logic          flit_parity;
`endif

  noc_flit_serializer #(.BIT_WIDTH(BW), .FLIT_WIDTH(FW)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .pkt_in     (pkt_in),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .flit_out   (flit_out),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready),
    .flit_head  (flit_head),
    .flit_tail  (flit_tail),
    .busy       (busy)
`ifdef NOC_FLIT_PARITY_EN
    ,
    .flit_parity(flit_parity)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [FW-1:0] data;
    logic          head;
    logic          tail;
  } exp_t;

  exp_t exp_q[$];

  task automatic chkw(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_pkt();
    logic [BW-1:0] v;
    for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Monitor: reference packets split into flits on accept; popped and compared on every transfer
  logic          stall_v;
  logic [FW-1:0] hold_data;
  logic          hold_head, hold_tail;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_l) begin
      exp_q.delete();
      stall_v <= 1'b0;
    end else begin
      if (stall_v) begin
        chk1("hold_valid", flit_valid, 1'b1);
        chkw("hold_data", flit_out, hold_data);
        chk1("hold_head", flit_head, hold_head);
        chk1("hold_tail", flit_tail, hold_tail);
      end
      stall_v   <= flit_valid && !flit_ready;
      hold_data <= flit_out;
      hold_head <= flit_head;
      hold_tail <= flit_tail;
      if (flit_valid && flit_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected_flit: got %h expected no flit", flit_out);
        end else begin
          e = exp_q.pop_front();
          chkw("sb_data", flit_out, e.data);
          chk1("sb_head", flit_head, e.head);
          chk1("sb_tail", flit_tail, e.tail);
`ifdef NOC_FLIT_PARITY_EN
          chk1("sb_parity", flit_parity, ^e.data);
`endif
        end
      end
      if (pkt_valid && pkt_ready) begin
        for (int i = 0; i < NF; i++) begin
          e.data = pkt_in[i*FW +: FW];
          e.head = (i == 0);
          e.tail = (i == NF - 1);
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    pkt_valid  = 1'b0;
    flit_ready = 1'b1;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending flits expected 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [BW-1:0] p, p2;
    logic [FW-1:0] ef;
    int            nvalid;

    rst_l = 1'b0; pkt_valid = 1'b0; flit_ready = 1'b0; pkt_in = '0;
    #12;
    chk1("rst_pkt_ready", pkt_ready, 1'b0);
    chk1("rst_flit_valid", flit_valid, 1'b0);
    chkw("rst_flit_out", flit_out, '0);
    chk1("rst_head", flit_head, 1'b0);
    chk1("rst_tail", flit_tail, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_l = 1'b1;
    #1;
    chk1("post_rst_pkt_ready", pkt_ready, 1'b1);
    chk1("post_rst_busy", busy, 1'b0);

    // single packet A,B,C,D with link always ready
    pkt_in = {128'hD, 128'hC, 128'hB, 128'hA};
    pkt_valid = 1'b1; flit_ready = 1'b1;
    step();
    pkt_valid = 1'b0;
    for (int i = 0; i < NF; i++) begin
      ef = 128'hA + 128'(i);
      chk1("single_valid", flit_valid, 1'b1);
      chkw("single_data", flit_out, ef);
      chk1("single_head", flit_head, i == 0);
      chk1("single_tail", flit_tail, i == NF - 1);
      chk1("single_pkt_ready", pkt_ready, i == NF - 1);
      step();
    end
    chk1("single_end_valid", flit_valid, 1'b0);
    chk1("single_end_pkt_ready", pkt_ready, 1'b1);
    drain();

    // backpressure on flit B for three cycles
    p = rand_pkt();
    pkt_in = p; pkt_valid = 1'b1;
    step();
    pkt_valid = 1'b0;
    step();
    flit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chkw("bp_data", flit_out, p[FW +: FW]);
      chk1("bp_valid", flit_valid, 1'b1);
      chk1("bp_head", flit_head, 1'b0);
      chk1("bp_tail", flit_tail, 1'b0);
      chk1("bp_pkt_ready", pkt_ready, 1'b0);
      step();
    end
    flit_ready = 1'b1;
    chkw("bp_release_data", flit_out, p[FW +: FW]);
    step();
    chkw("bp_next_data", flit_out, p[2*FW +: FW]);
    chk1("bp_next_pkt_ready", pkt_ready, 1'b0);
    step(); step();
    chk1("bp_end_valid", flit_valid, 1'b0);
    drain();

    // back-to-back packets with pkt_valid held high
    p = rand_pkt(); p2 = rand_pkt();
    pkt_in = p; pkt_valid = 1'b1; flit_ready = 1'b1;
    step();
    pkt_in = p2;
    nvalid = 0;
    for (int i = 0; i < 2 * NF; i++) begin
      if (flit_valid) nvalid++;
      chk1("b2b_pkt_ready", pkt_ready, (i % NF) == NF - 1);
      chk1("b2b_head", flit_head, (i % NF) == 0);
      chkw("b2b_data", flit_out, (i < NF) ? p[i*FW +: FW] : p2[(i-NF)*FW +: FW]);
      step();
      if (i == NF - 1) pkt_valid = 1'b0;
    end
    chki("b2b_flit_count", nvalid, 2 * NF);
    chk1("b2b_end_valid", flit_valid, 1'b0);
    drain();

    // reset while a packet is in flight
    p = rand_pkt();
    pkt_in = p; pkt_valid = 1'b1;
    step();
    pkt_valid = 1'b0;
    step(); step();
    #2 rst_l = 1'b0;
    #1;
    chk1("midrst_valid", flit_valid, 1'b0);
    chkw("midrst_data", flit_out, '0);
    chk1("midrst_pkt_ready", pkt_ready, 1'b0);
    @(posedge clk); #1;
    rst_l = 1'b1;
    #1;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_pkt_ready_after", pkt_ready, 1'b1);
    p = rand_pkt();
    pkt_in = p; pkt_valid = 1'b1;
    step();
    pkt_valid = 1'b0;
    chk1("midrst_new_head", flit_head, 1'b1);
    chkw("midrst_new_data", flit_out, p[FW-1:0]);
    drain();

    // pkt_in churn while busy with random link stalls
    pkt_in = rand_pkt(); pkt_valid = 1'b1;
    step();
    pkt_valid = 1'b0;
    for (int i = 0; i < 3 * NF; i++) begin
      pkt_in = rand_pkt();
      flit_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    drain();

`ifdef NOC_FLIT_PARITY_EN
    pkt_in = {128'h0, 128'h0, 128'h3, 128'h1}; pkt_valid = 1'b1; flit_ready = 1'b1;
    step();
    pkt_valid = 1'b0;
    chk1("parity_h1", flit_parity, 1'b1);
    step();
    chk1("parity_h3", flit_parity, 1'b0);
    drain();
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      pkt_in     = rand_pkt();
      pkt_valid  = ($urandom_range(0, 1) == 1);
      flit_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain();
    chki("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
